ervp_spsram_port_arbiter: RTL
=============================

Name: ervp_spsram_port_arbiter

Overview:
- Shares one single-port SRAM cell among NUM_REQ requesters. The cell has a 1-cycle synchronous read, byte-permit writes and a single index.
- Grants one access per cycle by round-robin, drives the cell port, and routes read data back to the granted requester over a valid/ready response channel with a 1-entry hold buffer.
- Sits between the SRAM controllers/DMA engines and each memory cell instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BW_INDEX, 13, cell word-index width
- BW_DATA, 128, cell word width
- BW_SUBWORD, 8, bits per write-permit bit; BW_WPERMIT = BW_DATA/BW_SUBWORD

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_list  in  NUM_REQ  per-requester request valid
- req_ready_list  out  NUM_REQ  per-requester request accept (one-hot or zero)
- req_write_list  in  NUM_REQ  1 = write, 0 = read
- req_index_list  in  NUM_REQ*BW_INDEX  packed index; requester i at slice [BW_INDEX*(i+1)-1 -: BW_INDEX]
- req_wpermit_list  in  NUM_REQ*BW_WPERMIT  packed write permits
- req_wdata_list  in  NUM_REQ*BW_DATA  packed write data
- rsp_valid_list  out  NUM_REQ  read response valid (one-hot or zero)
- rsp_ready_list  in  NUM_REQ  read response accept
- rsp_rdata  out  BW_DATA  shared read data, valid for the requester flagged in rsp_valid_list
- cell_index  out  BW_INDEX  to cell
- cell_enable  out  1  access strobe
- cell_wenable  out  1  write strobe
- cell_wpermit  out  BW_WPERMIT  byte/subword enables
- cell_wdata  out  BW_DATA  write data
- cell_renable  out  1  read strobe
- cell_rdata  in  BW_DATA  cell synchronous read data, valid the cycle after cell_renable
- busy  out  1  read response outstanding

Behaviour:
- Reset state: all outputs 0; state IDLE; rr_ptr = 0; hold register cleared. Reset mid-read drops the pending response; no rsp_valid after reset.
- Grant:
  - Eligible when state == IDLE, or when the outstanding response is accepted in the current cycle (rsp_valid & rsp_ready on the owner).
  - Winner = first requester with req_valid, scanning from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
  - req_ready asserted only to the winner.
  - On grant: rr_ptr <= winner+1 (wrap to 0).
- Cell drive (combinational, same cycle as grant):
  - cell_enable = 1; cell_index from the winner.
  - Write: cell_wenable = 1, cell_wpermit and cell_wdata from the winner, cell_renable = 0.
  - Read: cell_renable = 1, cell_wenable = 0, cell_wpermit = 0.
  - No grant: all cell strobes 0.
- Writes complete on handshake; no response.
- Read latency: grant at cycle T -> rsp_valid[owner] = 1 at T+1 with rsp_rdata = cell_rdata.
- FSM:
  - IDLE -> RSP on read grant.
  - RSP:
    - If owner rsp_ready: response done; next state RSP on a new read grant, IDLE otherwise.
    - Else: capture cell_rdata into hold, go HOLD.
  - HOLD: rsp_rdata = hold register; rsp_valid stays high until rsp_ready, then same exit as RSP.
- busy = (state != IDLE).
- Requesters hold req fields stable while req_valid = 1 and not ready. Deasserting req_valid without a handshake is legal and has no effect.
- req_ready depends combinationally on rsp_ready_list. No path from req_valid to rsp_valid.
- Back-to-back reads from the same requester with rsp_ready tied high sustain 1 access/cycle, interleaved round-robin with other requesters.

Optional Feature:
- ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN
  - Defined: rr_ptr is removed and the lowest-numbered valid requester always wins. Requester 0 can starve the others.
  - Undefined: round-robin as above.

Test Plan:
- Single read, requester 2, index 0x0010 (cell preloaded 0xA5..A5), rsp_ready = 1 -> cell_renable at T, rsp_valid_list = 4'b0100 at T+1, rsp_rdata = 0xA5..A5, busy back to 0 at T+2.
- Write requester 1, index 0x0003, wpermit 0x000F, wdata 0x11223344 in low word; then read same index -> low 4 bytes 0x11223344, other bytes unchanged.
- All 4 requesters reading continuously, rsp_ready all 1 -> grant order 0,1,2,3,0,... and one access per cycle.
- Read by requester 3 with rsp_ready low for 5 cycles:
  - Response moves to HOLD; rsp_rdata stays stable.
  - No req_ready to anyone for those cycles.
  - On the rsp_ready cycle, the next grant occurs the same cycle.
- Assert rst in the cycle after a read grant -> rsp_valid_list = 0 next cycle, rr_ptr = 0, first post-reset grant goes to requester 0 if valid.
- With ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN, requesters 0 and 2 valid continuously -> requester 0 granted every cycle, requester 2 never granted.

Source files
------------

// File: rtl/ervp_spsram_port_arbiter.sv
// ervp_spsram_port_arbiter: round-robin sharing of one single-port SRAM cell with a held read-response channel.
// Define ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module ervp_spsram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BW_INDEX = 13,
    parameter int BW_DATA = 128,
    parameter int BW_SUBWORD = 8,
    localparam int BW_WPERMIT = BW_DATA / BW_SUBWORD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_list,
    output logic [NUM_REQ-1:0]            req_ready_list,
    input  logic [NUM_REQ-1:0]            req_write_list,
    input  logic [NUM_REQ*BW_INDEX-1:0]   req_index_list,
    input  logic [NUM_REQ*BW_WPERMIT-1:0] req_wpermit_list,
    input  logic [NUM_REQ*BW_DATA-1:0]    req_wdata_list,
    output logic [NUM_REQ-1:0]            rsp_valid_list,
    input  logic [NUM_REQ-1:0]            rsp_ready_list,
    output logic [BW_DATA-1:0]            rsp_rdata,
    output logic [BW_INDEX-1:0]           cell_index,
    output logic                          cell_enable,
    output logic                          cell_wenable,
    output logic [BW_WPERMIT-1:0]         cell_wpermit,
    output logic [BW_DATA-1:0]            cell_wdata,
    output logic                          cell_renable,
    input  logic [BW_DATA-1:0]            cell_rdata,
    output logic                          busy
);
    localparam int BW_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RSP, HOLD} state_t;

    state_t              state_q, state_d;
    logic [BW_REQ-1:0]   owner_q, owner_d;
    logic [BW_DATA-1:0]  hold_q, hold_d;
    logic [BW_REQ-1:0]   winner, scan_base;
    logic                found, grant, rsp_done, eligible, win_write;

`ifdef ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN
    assign scan_base = '0;
`else
    logic [BW_REQ-1:0] rr_ptr_q, rr_ptr_d;
    assign scan_base = rr_ptr_q;
    assign rr_ptr_d = grant ? ((winner == BW_REQ'(NUM_REQ - 1)) ? '0 : winner + 1'b1) : rr_ptr_q;
`endif

    always_comb begin
        found = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_list[BW_REQ'((int'(scan_base) + k) % NUM_REQ)]) begin
                found = 1'b1;
                winner = BW_REQ'((int'(scan_base) + k) % NUM_REQ);
            end
        end
    end

    // A new grant may overlap the cycle in which the outstanding response is accepted.
    assign rsp_done = (state_q != IDLE) && rsp_ready_list[owner_q];
    assign eligible = (state_q == IDLE) || rsp_done;
    assign grant = eligible && found;
    assign win_write = req_write_list[winner];

    assign req_ready_list = grant ? NUM_REQ'(1) << winner : '0;
    assign rsp_valid_list = (state_q != IDLE) ? NUM_REQ'(1) << owner_q : '0;
    assign rsp_rdata = (state_q == HOLD) ? hold_q : (state_q == RSP) ? cell_rdata : '0;
    assign busy = (state_q != IDLE);

    assign cell_enable = grant;
    assign cell_wenable = grant && win_write;
    assign cell_renable = grant && !win_write;
    assign cell_index = grant ? req_index_list[BW_INDEX*winner +: BW_INDEX] : '0;
    assign cell_wpermit = cell_wenable ? req_wpermit_list[BW_WPERMIT*winner +: BW_WPERMIT] : '0;
    assign cell_wdata = cell_wenable ? req_wdata_list[BW_DATA*winner +: BW_DATA] : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d = hold_q;
        if (grant && !win_write) begin
            state_d = RSP;
            owner_d = winner;
        end else if (eligible) begin
            state_d = IDLE;
        end else if (state_q == RSP) begin
            state_d = HOLD;
            hold_d = cell_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            hold_q <= '0;
`ifndef ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q <= hold_d;
`ifndef ERVP_SPSRAM_ARB_FIXED_PRIORITY_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end
endmodule
